// File: rtl/qpsk_symbol_scheduler_pkg.sv
// Shared definitions for the QPSK symbol scheduler: CtrlPort register map,
// REG_CTRL bit positions and the scheduler FSM encoding.
package qpsk_symbol_scheduler_pkg;

    localparam logic [19:0] REG_REPEAT = 20'h0;
    localparam logic [19:0] REG_CTRL   = 20'h4;
    localparam logic [19:0] REG_SYMCNT = 20'h8;
    localparam logic [19:0] REG_STATUS = 20'hC;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_MSB_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } sched_state_t;

    // Observable FSM snapshot; busy status and out_tlast are derived from it.
    typedef struct packed {
        sched_state_t state;
        logic         last_beat;
    } sched_dbg_t;

endpackage

// File: rtl/qpsk_symbol_scheduler_regs.sv
// CtrlPort register file: repeat count with clamping, enable/bit-order control,
// symbol counter and busy status. Every request is acknowledged one cycle later.
module qpsk_symbol_scheduler_regs
    import qpsk_symbol_scheduler_pkg::*;
#(
    parameter int MAX_REPEAT        = 16,
    parameter int REP_W             = 5,
    parameter int DEFAULT_REPEAT    = 4,
    parameter bit DEFAULT_MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_wr,
    input  logic             req_rd,
    input  logic [19:0]      req_addr,
    input  logic [31:0]      req_data,
    input  logic             sym_beat,
    input  logic             busy,
    output logic             resp_ack,
    output logic [31:0]      resp_data,
    output logic [REP_W-1:0] rep_cfg,
    output logic             enable,
    output logic             msb_first
);

    logic [31:0]      sym_cnt;
    logic [31:0]      rd_data;
    logic [REP_W-1:0] wr_rep;

    always_comb begin
        rd_data = 32'd0;
        case (req_addr)
            REG_REPEAT: rd_data = 32'(rep_cfg);
            REG_CTRL:   rd_data = {30'd0, msb_first, enable};
            REG_SYMCNT: rd_data = sym_cnt;
            REG_STATUS: rd_data = {31'd0, busy};
            default:    rd_data = 32'd0;
        endcase
    end

    // A repeat of zero would never emit, so it is promoted to one.
    always_comb begin
        wr_rep = req_data[REP_W-1:0];
        if (req_data == 32'd0) begin
            wr_rep = REP_W'(1);
        end else if (req_data > 32'(MAX_REPEAT)) begin
            wr_rep = REP_W'(MAX_REPEAT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_ack  <= 1'b0;
            resp_data <= 32'd0;
            rep_cfg   <= REP_W'(DEFAULT_REPEAT);
            enable    <= 1'b0;
            msb_first <= DEFAULT_MSB_FIRST;
            sym_cnt   <= 32'd0;
        end else begin
            resp_ack  <= req_rd | req_wr;
            resp_data <= req_rd ? rd_data : 32'd0;
            if (req_wr) begin
                case (req_addr)
                    REG_REPEAT: rep_cfg <= wr_rep;
                    REG_CTRL: begin
                        enable    <= req_data[CTRL_EN_BIT];
                        msb_first <= req_data[CTRL_MSB_BIT];
                    end
                    default: ;
                endcase
            end
            if (req_wr && req_addr == REG_SYMCNT) begin
                sym_cnt <= 32'd0;
            end else if (sym_beat) begin
                sym_cnt <= sym_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// Splits each 32-bit input word into 16 dibits and emits each dibit rep_sh
// times; repeat and bit order are snapshotted per word at acceptance.
module qpsk_symbol_scheduler
    import qpsk_symbol_scheduler_pkg::*;
#(
    parameter int MAX_REPEAT        = 16,
    parameter int REP_W             = 5,
    parameter int DEFAULT_REPEAT    = 4,
    parameter bit DEFAULT_MSB_FIRST = 1'b1
) (
    input  logic        axis_data_clk,
    input  logic        axis_data_rst,
    input  logic        s_ctrlport_req_wr,
    input  logic        s_ctrlport_req_rd,
    input  logic [19:0] s_ctrlport_req_addr,
    input  logic [31:0] s_ctrlport_req_data,
    output logic        s_ctrlport_resp_ack,
    output logic [31:0] s_ctrlport_resp_data,
    input  logic [31:0] in_tdata,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [31:0] out_tdata,
    output logic        out_tlast,
    output logic        out_tvalid,
    input  logic        out_tready
);

    // Both streams use AXI-Stream semantics: a beat transfers on a rising edge
    // where valid && ready; valid never drops and data/last never change
    // until that beat transfers.

    sched_state_t     state, state_nx;
    sched_dbg_t       dbg;
    logic [31:0]      word_sh;
    logic             tlast_sh;
    logic [REP_W-1:0] rep_sh;
    logic             ord_sh;
    logic [3:0]       idx;
    logic [REP_W-1:0] rcnt;
    logic             last_rep;
    logic             out_hs;
    logic [4:0]       shamt;
    logic [1:0]       dibit;
    logic [REP_W-1:0] rep_cfg;
    logic             enable;
    logic             msb_first;

    assign last_rep      = (rcnt == rep_sh - REP_W'(1));
    assign out_hs        = out_tvalid & out_tready;
    assign dbg.state     = state;
    assign dbg.last_beat = (idx == 4'hF) && last_rep;

    always_comb begin
        state_nx   = state;
        in_tready  = 1'b0;
        out_tvalid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_tready = enable;
                if (enable && in_tvalid) begin
                    state_nx = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_tvalid = 1'b1;
                if (out_tready && dbg.last_beat) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_data_clk) begin
        if (axis_data_rst) begin
            state    <= ST_IDLE;
            word_sh  <= 32'd0;
            tlast_sh <= 1'b0;
            rep_sh   <= REP_W'(1);
            ord_sh   <= 1'b0;
            idx      <= 4'd0;
            rcnt     <= '0;
        end else begin
            state <= state_nx;
            if (in_tready && in_tvalid) begin
                word_sh  <= in_tdata;
                tlast_sh <= in_tlast;
                rep_sh   <= rep_cfg;
                ord_sh   <= msb_first;
                idx      <= 4'd0;
                rcnt     <= '0;
            end else if (out_hs) begin
                if (last_rep) begin
                    rcnt <= '0;
                    idx  <= idx + 4'd1;
                end else begin
                    rcnt <= rcnt + REP_W'(1);
                end
            end
        end
    end

    // MSB-first dibit i sits at bit 30-2i = 2*(15-i) = 2*~i.
    assign shamt     = ord_sh ? {~idx, 1'b0} : {idx, 1'b0};
    assign dibit     = word_sh[shamt +: 2];
    assign out_tdata = out_tvalid ? {30'd0, dibit} : 32'd0;
    assign out_tlast = out_tvalid & tlast_sh & dbg.last_beat;

    qpsk_symbol_scheduler_regs #(
        .MAX_REPEAT       (MAX_REPEAT),
        .REP_W            (REP_W),
        .DEFAULT_REPEAT   (DEFAULT_REPEAT),
        .DEFAULT_MSB_FIRST(DEFAULT_MSB_FIRST)
    ) u_regs (
        .clk      (axis_data_clk),
        .rst      (axis_data_rst),
        .req_wr   (s_ctrlport_req_wr),
        .req_rd   (s_ctrlport_req_rd),
        .req_addr (s_ctrlport_req_addr),
        .req_data (s_ctrlport_req_data),
        .sym_beat (out_hs),
        .busy     (dbg.state == ST_EMIT),
        .resp_ack (s_ctrlport_resp_ack),
        .resp_data(s_ctrlport_resp_data),
        .rep_cfg  (rep_cfg),
        .enable   (enable),
        .msb_first(msb_first)
    );

endmodule
